// File: rtl/dp_ram_mbist_if.sv
// Bus bundle for dp_ram_mbist: functional read/write ports, BIST control and
// status, and the verification fault-injection hook.
interface dp_ram_mbist_if #(
   parameter int ADDR_WIDTH = 6,
   parameter int DATA_WIDTH = 32
);
   logic                  rd_en;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  rd_valid;
   logic                  wr_en;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic [DATA_WIDTH-1:0] wr_mask;
   logic                  busy;
   logic                  bist_start;
   logic                  bist_done;
   logic                  bist_fail;
   logic [ADDR_WIDTH-1:0] bist_fail_addr;
   logic [2:0]            bist_fail_elem;
   logic                  inj_en;
   logic [ADDR_WIDTH-1:0] inj_addr;

   modport master (
      output rd_en, rd_addr, wr_en, wr_addr, wr_data, wr_mask,
             bist_start, inj_en, inj_addr,
      input  rd_data, rd_valid, busy, bist_done, bist_fail,
             bist_fail_addr, bist_fail_elem
   );

   modport slave (
      input  rd_en, rd_addr, wr_en, wr_addr, wr_data, wr_mask,
             bist_start, inj_en, inj_addr,
      output rd_data, rd_valid, busy, bist_done, bist_fail,
             bist_fail_addr, bist_fail_elem
   );
endinterface

// File: rtl/dp_ram_mbist.sv
// Dual-port RAM (one read, one write port) with optional zero-init after reset
// and a March C- self-test engine. Functional traffic is ignored while busy.
module dp_ram_mbist #(
   parameter int                    ADDR_WIDTH           = 6,
   parameter int                    DATA_WIDTH           = 32,
   parameter int                    INIT_MEMORY_ON_RESET = 1,
   parameter logic [DATA_WIDTH-1:0] BIST_BACKGROUND      = '0
) (
   input logic           clk,
   input logic           rst,
   dp_ram_mbist_if.slave bus
);

   localparam int                    DEPTH    = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

   typedef enum logic [3:0] {
      S_IDLE, S_INIT, S_M0, S_M1, S_M2, S_M3, S_M4, S_M5, S_DRAIN, S_DONE
   } state_t;

   // March element number reported on a failure (reading elements only)
   function automatic logic [2:0] elem_of(input state_t s);
      case (s)
         S_M1:    return 3'd1;
         S_M2:    return 3'd2;
         S_M3:    return 3'd3;
         S_M4:    return 3'd4;
         S_M5:    return 3'd5;
         default: return 3'd0;
      endcase
   endfunction

   // Element sequencing; the last element hands over to the compare drain
   function automatic state_t next_elem(input state_t s);
      case (s)
         S_M0:    return S_M1;
         S_M1:    return S_M2;
         S_M2:    return S_M3;
         S_M3:    return S_M4;
         S_M4:    return S_M5;
         S_M5:    return S_DRAIN;
         default: return S_IDLE;
      endcase
   endfunction

   state_t                state_q;
   logic [ADDR_WIDTH-1:0] cnt_q;
   logic                  busy_q;
   logic                  done_q;
   logic                  fail_q;
   logic [ADDR_WIDTH-1:0] fail_addr_q;
   logic [2:0]            fail_elem_q;
   logic                  rd_valid_q;
   logic [DATA_WIDTH-1:0] rd_data_q;

   // compare pipeline, stage 1: registered BIST read with its expectation
   logic                  vld_p1_q;
   logic [DATA_WIDTH-1:0] rdata_p1_q;
   logic [DATA_WIDTH-1:0] exp_p1_q;
   logic [ADDR_WIDTH-1:0] addr_p1_q;
   logic [2:0]            elem_p1_q;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic                  march_rd;
   logic                  march_wr;
   logic                  march_desc;
   logic [ADDR_WIDTH-1:0] march_addr;
   logic [DATA_WIDTH-1:0] exp_rd;
   logic [DATA_WIDTH-1:0] wr_pat;
   logic                  func_rd;
   logic [ADDR_WIDTH-1:0] rd_addr_mux;
   logic [DATA_WIDTH-1:0] rdata;
   logic                  we_mux;
   logic [ADDR_WIDTH-1:0] waddr_mux;
   logic [DATA_WIDTH-1:0] wdata_mux;
   logic [DATA_WIDTH-1:0] wmask_mux;
   logic                  mismatch;

   assign march_rd   = state_q inside {S_M1, S_M2, S_M3, S_M4, S_M5};
   assign march_wr   = state_q inside {S_M0, S_M1, S_M2, S_M3, S_M4};
   assign march_desc = state_q inside {S_M3, S_M4};
   // Descending sweeps reuse the up-counter by inverting it
   assign march_addr = march_desc ? ~cnt_q : cnt_q;
   assign exp_rd     = (state_q inside {S_M2, S_M4}) ? ~BIST_BACKGROUND : BIST_BACKGROUND;
   assign wr_pat     = (state_q inside {S_M1, S_M3}) ? ~BIST_BACKGROUND : BIST_BACKGROUND;
   assign func_rd    = bus.rd_en & ~busy_q;
   assign mismatch   = vld_p1_q & (rdata_p1_q != exp_p1_q);

   // Read port address mux and array read with optional stuck-at-1 on bit 0
   always_comb begin
      rd_addr_mux = march_rd ? march_addr : bus.rd_addr;
      rdata       = mem_q[rd_addr_mux];
      if (bus.inj_en && (rd_addr_mux == bus.inj_addr)) begin
         rdata[0] = 1'b1;
      end
   end

   // Write port mux: INIT over BIST over functional traffic
   always_comb begin
      we_mux    = 1'b0;
      waddr_mux = bus.wr_addr;
      wdata_mux = bus.wr_data;
      wmask_mux = bus.wr_mask;
      if (state_q == S_INIT && busy_q) begin
         we_mux    = 1'b1;
         waddr_mux = cnt_q;
         wdata_mux = '0;
         wmask_mux = '1;
      end else if (march_wr) begin
         we_mux    = 1'b1;
         waddr_mux = march_addr;
         wdata_mux = wr_pat;
         wmask_mux = '1;
      end else if (bus.wr_en && !busy_q) begin
         we_mux    = 1'b1;
      end
   end

   // Storage array: bit-masked write, no reset on contents
   always_ff @(posedge clk) begin
      if (we_mux) begin
         mem_q[waddr_mux] <= (mem_q[waddr_mux] & ~wmask_mux) | (wdata_mux & wmask_mux);
      end
   end

   // Capture BIST read data with its expectation and tag for next-cycle compare
   always_ff @(posedge clk) begin
      if (march_rd) begin
         rdata_p1_q <= rdata;
         exp_p1_q   <= exp_rd;
         addr_p1_q  <= march_addr;
         elem_p1_q  <= elem_of(state_q);
      end
   end

   // Functional read register and compare-valid flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
         vld_p1_q   <= 1'b0;
      end else begin
         rd_valid_q <= func_rd;
         vld_p1_q   <= march_rd;
         if (func_rd) begin
            rd_data_q <= rdata;
         end
      end
   end

   // Control FSM: init sweep, March C- sequencing and result flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= (INIT_MEMORY_ON_RESET != 0) ? S_INIT : S_IDLE;
         cnt_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         fail_q      <= 1'b0;
         fail_addr_q <= '0;
         fail_elem_q <= '0;
      end else begin
         if (mismatch) begin
            fail_q <= 1'b1;
            if (!fail_q) begin
               fail_addr_q <= addr_p1_q;
               fail_elem_q <= elem_p1_q;
            end
         end
         case (state_q)
            S_INIT: begin
               // first cycle after reset only raises busy; writes follow
               if (!busy_q) begin
                  busy_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + ADDR_WIDTH'(1);
                  if (cnt_q == ADDR_MAX) begin
                     state_q <= S_IDLE;
                     busy_q  <= 1'b0;
                  end
               end
            end
            S_IDLE, S_DONE: begin
               if (bus.bist_start) begin
                  state_q     <= S_M0;
                  cnt_q       <= '0;
                  busy_q      <= 1'b1;
                  done_q      <= 1'b0;
                  fail_q      <= 1'b0;
                  fail_addr_q <= '0;
                  fail_elem_q <= '0;
               end
            end
            S_M0, S_M1, S_M2, S_M3, S_M4, S_M5: begin
               cnt_q <= cnt_q + ADDR_WIDTH'(1);
               if (cnt_q == ADDR_MAX) begin
                  state_q <= next_elem(state_q);
               end
            end
            S_DRAIN: begin
               // two cycles: array read register, then the compare itself
               cnt_q <= cnt_q + ADDR_WIDTH'(1);
               if (cnt_q == ADDR_WIDTH'(1)) begin
                  state_q <= S_DONE;
                  cnt_q   <= '0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.rd_data        = rd_data_q;
   assign bus.rd_valid       = rd_valid_q;
   assign bus.busy           = busy_q;
   assign bus.bist_done      = done_q;
   assign bus.bist_fail      = fail_q;
   assign bus.bist_fail_addr = fail_addr_q;
   assign bus.bist_fail_elem = fail_elem_q;

endmodule

// File: tb/tb_dp_ram_mbist.sv
// Bench for dp_ram_mbist: two instances (background 0 and 0xA5A5A5A5) driven
// with random traffic and checked against a word-array model of the RAM and
// an element-by-element March C- model.
module tb_dp_ram_mbist;

   localparam int          AW       = 6;
   localparam int          DW       = 32;
   localparam int          DEPTH    = 64;
   localparam int          BIST_LAT = 6 * DEPTH + 2;
   localparam logic [31:0] BG1      = 32'hA5A5_A5A5;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic          rd_en      [2];
   logic [AW-1:0] rd_addr    [2];
   logic          wr_en      [2];
   logic [AW-1:0] wr_addr    [2];
   logic [DW-1:0] wr_data    [2];
   logic [DW-1:0] wr_mask    [2];
   logic          bist_start [2];
   logic          inj_en     [2];
   logic [AW-1:0] inj_addr   [2];

   logic [DW-1:0] rd_data_w   [2];
   logic          rd_valid_w  [2];
   logic          busy_w      [2];
   logic          done_w      [2];
   logic          fail_w      [2];
   logic [AW-1:0] faddr_w     [2];
   logic [2:0]    felem_w     [2];

   logic [31:0] mdl     [2][DEPTH];
   logic [31:0] last_rd [2];
   logic [31:0] bgv     [2];

   int total = 0;
   int bad   = 0;

   dp_ram_mbist_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if0 ();
   dp_ram_mbist_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if1 ();

   dp_ram_mbist #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INIT_MEMORY_ON_RESET(1),
                  .BIST_BACKGROUND(32'h0))
      dut0 (.clk(clk), .rst(rst), .bus(if0.slave));

   dp_ram_mbist #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INIT_MEMORY_ON_RESET(1),
                  .BIST_BACKGROUND(BG1))
      dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

   assign if0.rd_en = rd_en[0];      assign if1.rd_en = rd_en[1];
   assign if0.rd_addr = rd_addr[0];  assign if1.rd_addr = rd_addr[1];
   assign if0.wr_en = wr_en[0];      assign if1.wr_en = wr_en[1];
   assign if0.wr_addr = wr_addr[0];  assign if1.wr_addr = wr_addr[1];
   assign if0.wr_data = wr_data[0];  assign if1.wr_data = wr_data[1];
   assign if0.wr_mask = wr_mask[0];  assign if1.wr_mask = wr_mask[1];
   assign if0.bist_start = bist_start[0];  assign if1.bist_start = bist_start[1];
   assign if0.inj_en = inj_en[0];    assign if1.inj_en = inj_en[1];
   assign if0.inj_addr = inj_addr[0];  assign if1.inj_addr = inj_addr[1];

   assign rd_data_w[0] = if0.rd_data;   assign rd_data_w[1] = if1.rd_data;
   assign rd_valid_w[0] = if0.rd_valid; assign rd_valid_w[1] = if1.rd_valid;
   assign busy_w[0] = if0.busy;         assign busy_w[1] = if1.busy;
   assign done_w[0] = if0.bist_done;    assign done_w[1] = if1.bist_done;
   assign fail_w[0] = if0.bist_fail;    assign fail_w[1] = if1.bist_fail;
   assign faddr_w[0] = if0.bist_fail_addr;  assign faddr_w[1] = if1.bist_fail_addr;
   assign felem_w[0] = if0.bist_fail_elem;  assign felem_w[1] = if1.bist_fail_elem;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // March C- applied word by word to the model array; returns first mismatch
   task automatic march_model(input int d, input bit inj, input int ia,
                              output bit f, output int fa, output int fe);
      logic [31:0] bg;
      logic [31:0] rv;
      logic [31:0] ev;
      int a;
      bg = bgv[d];
      f = 1'b0; fa = 0; fe = 0;
      for (int e = 0; e < 6; e++) begin
         for (int i = 0; i < DEPTH; i++) begin
            a = (e == 3 || e == 4) ? (DEPTH - 1 - i) : i;
            if (e > 0) begin
               rv = mdl[d][a];
               if (inj && a == ia) rv[0] = 1'b1;
               ev = (e == 2 || e == 4) ? ~bg : bg;
               if (rv !== ev && !f) begin
                  f = 1'b1; fa = a; fe = e;
               end
            end
            if (e < 5) mdl[d][a] = (e == 1 || e == 3) ? ~bg : bg;
         end
      end
   endtask

   task automatic wait_init(input string tag);
      int  cnt  [2];
      bit  seen [2];
      bit  fin  [2];
      for (int d = 0; d < 2; d++) begin
         cnt[d] = 0; seen[d] = 1'b0; fin[d] = 1'b0;
      end
      rst = 1'b0;
      for (int i = 0; i < 300; i++) begin
         step();
         // a start request during the init sweep must be ignored
         if (i == 10) begin bist_start[0] = 1'b1; bist_start[1] = 1'b1; end
         if (i == 12) begin bist_start[0] = 1'b0; bist_start[1] = 1'b0; end
         for (int d = 0; d < 2; d++) begin
            if (!fin[d]) begin
               if (busy_w[d] === 1'b1) begin
                  cnt[d]++; seen[d] = 1'b1;
               end else if (seen[d]) begin
                  fin[d] = 1'b1;
               end
            end
         end
         if (fin[0] && fin[1]) break;
      end
      step(); step();
      for (int d = 0; d < 2; d++) begin
         total++;
         if (cnt[d] !== DEPTH) begin
            bad++;
            $display("FAIL %s_busy_len d%0d: got %0d want %0d", tag, d, cnt[d], DEPTH);
         end
         total++;
         if ({busy_w[d], done_w[d]} !== 2'b00) begin
            bad++;
            $display("FAIL %s_idle d%0d: busy/done got %b%b want 00", tag, d, busy_w[d], done_w[d]);
         end
         for (int a = 0; a < DEPTH; a++) mdl[d][a] = '0;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step(); step();
      for (int d = 0; d < 2; d++) begin
         total++;
         if ({busy_w[d], done_w[d], fail_w[d], rd_valid_w[d]} !== 4'b0) begin
            bad++;
            $display("FAIL reset_flags d%0d: got %b want 0000", d,
                     {busy_w[d], done_w[d], fail_w[d], rd_valid_w[d]});
         end
         total++;
         if (rd_data_w[d] !== 32'h0 || faddr_w[d] !== '0 || felem_w[d] !== 3'd0) begin
            bad++;
            $display("FAIL reset_data d%0d: rd_data=%h addr=%0d elem=%0d want 0", d,
                     rd_data_w[d], faddr_w[d], felem_w[d]);
         end
         last_rd[d] = '0;
      end
      wait_init("reset_init");
   endtask

   task automatic test_init_read();
      for (int a = 0; a < DEPTH; a++) begin
         for (int d = 0; d < 2; d++) begin
            rd_en[d] = 1'b1; rd_addr[d] = AW'(a);
         end
         step();
         for (int d = 0; d < 2; d++) begin
            total++;
            if (rd_valid_w[d] !== 1'b1 || rd_data_w[d] !== mdl[d][a]) begin
               bad++;
               $display("FAIL init_read d%0d a%0d: got v=%b %h want v=1 %h", d, a,
                        rd_valid_w[d], rd_data_w[d], mdl[d][a]);
            end
            last_rd[d] = mdl[d][a];
         end
      end
      rd_en[0] = 1'b0; rd_en[1] = 1'b0;
      step();
      for (int d = 0; d < 2; d++) begin
         total++;
         if (rd_valid_w[d] !== 1'b0 || rd_data_w[d] !== last_rd[d]) begin
            bad++;
            $display("FAIL init_idle_hold d%0d: got v=%b %h want v=0 %h", d,
                     rd_valid_w[d], rd_data_w[d], last_rd[d]);
         end
      end
   endtask

   task automatic test_mask_rw(input int d, input int iters);
      logic [31:0] old;
      bit re, we;
      int ra, wa;
      logic [31:0] wd, wm;
      wr_en[d] = 1'b1; wr_addr[d] = 6'd3; wr_data[d] = 32'h1234_5678; wr_mask[d] = '1;
      step();
      mdl[d][3] = 32'h1234_5678;
      wr_data[d] = 32'hFFFF_FFFF; wr_mask[d] = 32'h0000_FFFF;
      rd_en[d] = 1'b1; rd_addr[d] = 6'd3;
      step();
      wr_en[d] = 1'b0;
      total++;
      if (rd_valid_w[d] !== 1'b1 || rd_data_w[d] !== 32'h1234_5678) begin
         bad++;
         $display("FAIL mask_old d%0d: got v=%b %h want v=1 12345678", d, rd_valid_w[d], rd_data_w[d]);
      end
      mdl[d][3] = 32'h1234_FFFF;
      step();
      rd_en[d] = 1'b0;
      total++;
      if (rd_data_w[d] !== 32'h1234_FFFF) begin
         bad++;
         $display("FAIL mask_new d%0d: got %h want 1234ffff", d, rd_data_w[d]);
      end
      last_rd[d] = 32'h1234_FFFF;
      for (int i = 0; i < iters; i++) begin
         re = 1'($urandom_range(0, 1));
         we = 1'($urandom_range(0, 1));
         ra = $urandom_range(0, DEPTH - 1);
         wa = ($urandom_range(0, 1) == 1) ? ra : $urandom_range(0, DEPTH - 1);
         wd = $urandom;
         wm = $urandom;
         rd_en[d] = re; rd_addr[d] = AW'(ra);
         wr_en[d] = we; wr_addr[d] = AW'(wa); wr_data[d] = wd; wr_mask[d] = wm;
         old = mdl[d][ra];
         step();
         if (re) last_rd[d] = old;
         total++;
         if (rd_valid_w[d] !== re || rd_data_w[d] !== last_rd[d]) begin
            bad++;
            $display("FAIL rand_rw d%0d it%0d: got v=%b %h want v=%b %h", d, i,
                     rd_valid_w[d], rd_data_w[d], re, last_rd[d]);
         end
         if (we) mdl[d][wa] = (mdl[d][wa] & ~wm) | (wd & wm);
      end
      rd_en[d] = 1'b0; wr_en[d] = 1'b0;
   endtask

   task automatic run_bist(input int d, input bit inj, input int ia, input bit mid_start,
                           input string tag);
      bit ef;
      int ea, ee, n, vbad;
      inj_en[d] = inj; inj_addr[d] = AW'(ia);
      march_model(d, inj, ia, ef, ea, ee);
      bist_start[d] = 1'b1;
      step();
      bist_start[d] = 1'b0;
      rd_en[d] = 1'b1; rd_addr[d] = AW'($urandom_range(0, DEPTH - 1));
      n = 0; vbad = 0;
      while (done_w[d] !== 1'b1 && n < 1000) begin
         step();
         n++;
         if (rd_valid_w[d] !== 1'b0) vbad++;
         if (n < BIST_LAT && busy_w[d] !== 1'b1) vbad++;
         if (mid_start && n == 50) bist_start[d] = 1'b1;
         if (n == 52) bist_start[d] = 1'b0;
      end
      rd_en[d] = 1'b0;
      total++;
      if (n !== BIST_LAT) begin
         bad++;
         $display("FAIL %s_latency d%0d: got %0d want %0d", tag, d, n, BIST_LAT);
      end
      total++;
      if (vbad !== 0) begin
         bad++;
         $display("FAIL %s_busy_block d%0d: got %0d bad cycles want 0", tag, d, vbad);
      end
      total++;
      if (fail_w[d] !== ef || busy_w[d] !== 1'b0) begin
         bad++;
         $display("FAIL %s_result d%0d: fail=%b busy=%b want fail=%b busy=0", tag, d,
                  fail_w[d], busy_w[d], ef);
      end
      if (ef) begin
         total++;
         if (faddr_w[d] !== AW'(ea) || felem_w[d] !== 3'(ee)) begin
            bad++;
            $display("FAIL %s_first d%0d: addr=%0d elem=%0d want addr=%0d elem=%0d", tag, d,
                     faddr_w[d], felem_w[d], ea, ee);
         end
      end
      if (inj) begin
         rd_en[d] = 1'b1; rd_addr[d] = AW'(ia);
         step();
         last_rd[d] = mdl[d][ia] | 32'h1;
         total++;
         if (rd_data_w[d] !== last_rd[d]) begin
            bad++;
            $display("FAIL %s_inj_read d%0d: got %h want %h", tag, d, rd_data_w[d], last_rd[d]);
         end
         inj_en[d] = 1'b0;
      end
      for (int a = 0; a < DEPTH; a++) begin
         rd_en[d] = 1'b1; rd_addr[d] = AW'(a);
         step();
         total++;
         if (rd_data_w[d] !== mdl[d][a]) begin
            bad++;
            $display("FAIL %s_contents d%0d a%0d: got %h want %h", tag, d, a, rd_data_w[d], mdl[d][a]);
         end
         last_rd[d] = mdl[d][a];
      end
      rd_en[d] = 1'b0;
      step();
   endtask

   task automatic test_bist_pass();
      run_bist(0, 1'b0, 0, 1'b1, "pass0");
   endtask

   task automatic test_bist_fault();
      run_bist(0, 1'b1, 5, 1'b0, "fault5");
      run_bist(0, 1'b1, $urandom_range(0, DEPTH - 1), 1'b0, "fault_rand");
   endtask

   task automatic test_bist_background();
      run_bist(1, 1'b1, 63, 1'b0, "bg_fault63");
      run_bist(1, 1'b0, 0, 1'b0, "bg_pass");
   endtask

   task automatic test_back_to_back();
      test_mask_rw(0, 30);
      test_mask_rw(1, 30);
      run_bist(0, 1'b0, 0, 1'b0, "b2b_pass");
   endtask

   task automatic test_reset_mid_bist();
      bit ef;
      int ea, ee;
      inj_en[0] = 1'b1; inj_addr[0] = 6'd5;
      march_model(0, 1'b1, 5, ef, ea, ee);
      bist_start[0] = 1'b1;
      step();
      bist_start[0] = 1'b0;
      for (int i = 0; i < 100; i++) step();
      total++;
      if (fail_w[0] !== 1'b1 || busy_w[0] !== 1'b1) begin
         bad++;
         $display("FAIL midrst_pre: fail=%b busy=%b want 1 1", fail_w[0], busy_w[0]);
      end
      rst = 1'b1;
      #1;
      total++;
      if ({busy_w[0], done_w[0], fail_w[0]} !== 3'b000 || faddr_w[0] !== '0 || felem_w[0] !== 3'd0) begin
         bad++;
         $display("FAIL midrst_clear: busy/done/fail=%b addr=%0d elem=%0d want 0", 
                  {busy_w[0], done_w[0], fail_w[0]}, faddr_w[0], felem_w[0]);
      end
      inj_en[0] = 1'b0;
      step(); step();
      last_rd[0] = '0; last_rd[1] = '0;
      wait_init("midrst_init");
      run_bist(0, 1'b0, 0, 1'b0, "midrst_rerun");
   endtask

   initial begin
      rst = 1'b1;
      bgv[0] = 32'h0;
      bgv[1] = BG1;
      for (int d = 0; d < 2; d++) begin
         rd_en[d] = 1'b0; rd_addr[d] = '0; wr_en[d] = 1'b0; wr_addr[d] = '0;
         wr_data[d] = '0; wr_mask[d] = '0; bist_start[d] = 1'b0;
         inj_en[d] = 1'b0; inj_addr[d] = '0;
      end
      test_reset();
      test_init_read();
      test_mask_rw(0, 40);
      test_mask_rw(1, 40);
      test_bist_pass();
      test_bist_fault();
      test_bist_background();
      test_back_to_back();
      test_reset_mid_bist();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
